ifetch_ctrl: RTL and testbench

- Fetch sequencer in front of the combinational instruction memory (16-bit PC in, 16-bit instruction out).
- Owns the fetch PC and buffers fetched words in a small prefetch queue feeding decode.
- Handles decode back-pressure, branch redirects (queue flush) and HALT detection (16'hFFFF), so the core sees a clean valid/stall instruction stream.

---
 rtl/ifetch_ctrl.sv | 123 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, buffers fetched words in a small prefetch queue,
// handles decode stalls, redirect flushes and HALT. Optional trace: define IFETCH_TRACE_EN.
module ifetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk_pi,
  input  logic        reset_n_pi,
  output logic [15:0] imem_pc_po,
  input  logic [15:0] imem_instr_pi,
  input  logic        stall_pi,
  input  logic        redirect_pi,
  input  logic [15:0] redirect_pc_pi,
  output logic [15:0] instr_po,
  output logic [15:0] instr_pc_po,
  output logic        instr_valid_po,
  output logic        halted_po
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_HALT_PEND, ST_HALTED} state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_q_pc    [QDEPTH];
  logic [15:0]   r_q_instr [QDEPTH];
  logic [PW-1:0] r_head, r_tail, w_head_next, w_tail_next;
  logic [CW-1:0] r_count, w_count_next, w_count_after_pop;
  logic [15:0]   r_fetch_pc, w_fetch_pc_next, w_redirect_target;
  logic [15:0]   r_instr, r_instr_pc, w_instr_next, w_instr_pc_next;
  logic          r_valid, w_valid_next;
  logic          w_pop, w_push, w_push_halt, w_redirect;

  assign w_redirect_target = redirect_pc_pi & 16'hFFFE;
  assign w_redirect        = redirect_pi && (r_state != ST_HALTED);
  assign w_pop             = r_valid && !stall_pi && !w_redirect;
  assign w_count_after_pop = r_count - CW'(w_pop);
  // A same-cycle pop frees a slot, so a full queue still accepts a push while draining.
  assign w_push            = (r_state == ST_RUN) && !w_redirect && (w_count_after_pop != FULL_CNT);
  assign w_push_halt       = w_push && (imem_instr_pi == HALT_WORD);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_head_next     = r_head;
    w_tail_next     = r_tail;
    w_count_next    = w_count_after_pop + CW'(w_push);
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    if (w_redirect) begin
      w_state_next    = ST_RUN;
      w_fetch_pc_next = w_redirect_target;
      w_head_next     = '0;
      w_tail_next     = '0;
      w_count_next    = '0;
    end else begin
      if (w_pop) w_head_next = r_head + 1'b1;
      if (w_push) begin
        w_tail_next = r_tail + 1'b1;
        if (w_push_halt) w_state_next = ST_HALT_PEND;
        else             w_fetch_pc_next = r_fetch_pc + 16'd2;
      end
      // While HALT is pending nothing is pushed, so the last remaining entry is the HALT word.
      if ((r_state == ST_HALT_PEND) && w_pop && (r_count == CW'(1))) w_state_next = ST_HALTED;
      if (w_count_after_pop != '0) begin
        w_instr_next    = r_q_instr[w_head_next];
        w_instr_pc_next = r_q_pc[w_head_next];
      end else if (w_push) begin
        w_instr_next    = imem_instr_pi;
        w_instr_pc_next = r_fetch_pc;
      end
    end
    w_valid_next = (w_count_next != '0) && (w_state_next != ST_HALTED);
  end

  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC & 16'hFFFE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_n_pi && w_push) begin
      r_q_pc[r_tail]    <= r_fetch_pc;
      r_q_instr[r_tail] <= imem_instr_pi;
    end
  end

`ifdef IFETCH_TRACE_EN
  always_ff @(posedge clk_pi) begin
    if (reset_n_pi && w_push)
      $display("IFETCH: Time:%3d PC: %2d Instruction: %x", $time, r_fetch_pc, imem_instr_pi);
    if (reset_n_pi && w_redirect)
      $display("IFETCH: Time:%3d flush, redirect to PC: %2d", $time, w_redirect_target);
  end
`endif

  assign imem_pc_po     = r_fetch_pc;
  assign instr_po       = r_instr;
  assign instr_pc_po    = r_instr_pc;
  assign instr_valid_po = r_valid;
  assign halted_po      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifetch_ctrl;

  localparam int TB_QD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  logic        halt_en = 1'b0;
  logic [15:0] halt_pc = 16'h000E;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(16'h0000), .HALT_WORD(16'hFFFF), .QDEPTH(TB_QD)) dut (
    .clk_pi(clk),
    .reset_n_pi(reset_n),
    .imem_pc_po(imem_pc),
    .imem_instr_pi(imem_instr),
    .stall_pi(stall),
    .redirect_pi(redirect),
    .redirect_pc_pi(redirect_pc),
    .instr_po(instr),
    .instr_pc_po(instr_pc),
    .instr_valid_po(instr_valid),
    .halted_po(halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] pc, input logic en, input logic [15:0] hpc);
    return (en && pc == hpc) ? 16'hFFFF : (pc ^ 16'h5A30);
  endfunction

  always_comb imem_instr = mem_word(imem_pc, halt_en, halt_pc);

  // Reference model: a plain FIFO of {pc, word} plus a few flags.
  logic [31:0] m_q[$];
  logic [15:0] m_pc, m_instr, m_ipc, m_w;
  logic [31:0] m_e;
  logic        m_valid, m_halt_pend, m_halted;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q.delete();
      m_pc = 16'h0000;
      m_halt_pend = 1'b0;
      m_halted = 1'b0;
      m_valid = 1'b0;
      m_instr = 16'h0000;
      m_ipc = 16'h0000;
    end else begin
      if (redirect && !m_halted) begin
        m_q.delete();
        m_pc = redirect_pc & 16'hFFFE;
        m_halt_pend = 1'b0;
      end else begin
        if (m_valid && !stall && m_q.size() > 0) begin
          m_e = m_q.pop_front();
          if (m_halt_pend && m_e[15:0] == 16'hFFFF) begin
            m_halted = 1'b1;
            m_halt_pend = 1'b0;
          end
        end
        if (!m_halted && !m_halt_pend && m_q.size() < TB_QD) begin
          m_w = mem_word(m_pc, halt_en, halt_pc);
          m_q.push_back({m_pc, m_w});
          if (m_w == 16'hFFFF) m_halt_pend = 1'b1;
          else m_pc = m_pc + 16'd2;
        end
      end
      if (m_q.size() > 0) begin
        m_instr = m_q[0][15:0];
        m_ipc = m_q[0][31:16];
      end
      m_valid = (m_q.size() > 0) && !m_halted;
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check every output against the model at the falling edge.
  task automatic cyc(input logic s, input logic r, input logic [15:0] rpc, input logic rn);
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    reset_n = rn;
    @(negedge clk);
    cmp("imem_pc", imem_pc, m_pc);
    cmp("valid", {15'd0, instr_valid}, {15'd0, m_valid});
    cmp("halted", {15'd0, halted}, {15'd0, m_halted});
    cmp("instr", instr, m_instr);
    cmp("instr_pc", instr_pc, m_ipc);
    $display("cycle t=%0t rn=%b st=%b rd=%b rpc=%h | pc=%h v=%b ipc=%h ins=%h h=%b",
             $time, rn, s, r, rpc, imem_pc, instr_valid, instr_pc, instr, halted);
  endtask

  logic s_r, r_r, rn_r;
  logic [15:0] rpc_r;

  initial begin
    // Reset and streaming with no stalls
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    cmp("lit_reset_valid", {15'd0, instr_valid}, 16'd0);
    cmp("lit_reset_pc", imem_pc, 16'h0000);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_first_valid", {15'd0, instr_valid}, 16'd1);
    cmp("lit_stream_pc0", instr_pc, 16'h0000);
    cmp("lit_stream_ins0", instr, 16'h5A30);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_stream_pc2", instr_pc, 16'h0002);
    cmp("lit_stream_ins2", instr, 16'h5A32);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_stream_pc4", instr_pc, 16'h0004);

    // Stall from start: queue fills with 0,2 and fetch holds at 4
    cyc(0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0, 1);
    cmp("lit_full_imem_pc", imem_pc, 16'h0004);
    cmp("lit_full_head", instr_pc, 16'h0000);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_drain_pc2", instr_pc, 16'h0002);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_drain_pc4", instr_pc, 16'h0004);
    cmp("lit_drain_ins4", instr, 16'h5A34);

    // Redirect to an odd target: bit 0 dropped, one empty cycle
    cyc(1, 1, 16'h0005, 1);
    cmp("lit_redir_valid", {15'd0, instr_valid}, 16'd0);
    cmp("lit_redir_pc", imem_pc, 16'h0004);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_redir_head", instr_pc, 16'h0004);
    cmp("lit_redir_valid2", {15'd0, instr_valid}, 16'd1);

    // HALT at PC 14, then a redirect that must be ignored
    halt_en = 1'b1;
    halt_pc = 16'h000E;
    cyc(0, 1, 16'h0000, 1);
    for (int i = 0; i < 60; i++) begin
      if (halted) break;
      cyc(0, 0, 16'h0, 1);
    end
    cmp("lit_halted", {15'd0, halted}, 16'd1);
    cmp("lit_halt_pc", imem_pc, 16'h000E);
    cyc(0, 1, 16'h0020, 1);
    cmp("lit_halt_sticky", {15'd0, halted}, 16'd1);
    cmp("lit_halt_redir_ign", imem_pc, 16'h000E);

    // HALT pending behind PC 12, redirect to 4 cancels it
    cyc(1, 0, 16'h0, 0);
    cyc(1, 0, 16'h0, 1);
    cyc(1, 1, 16'h000C, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0, 1);
    cmp("lit_pend_pc", imem_pc, 16'h000E);
    cmp("lit_pend_head", instr_pc, 16'h000C);
    cyc(0, 1, 16'h0004, 1);
    cmp("lit_pend_cancel_h", {15'd0, halted}, 16'd0);
    cmp("lit_pend_cancel_pc", imem_pc, 16'h0004);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_pend_resume", instr_pc, 16'h0004);

    // Wrap-around from FFFC, then reset mid-stream
    halt_en = 1'b0;
    cyc(0, 1, 16'hFFFD, 1);
    cmp("lit_wrap_fetch", imem_pc, 16'hFFFC);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_wrap_fffc", instr_pc, 16'hFFFC);
    cmp("lit_wrap_ins", instr, 16'hA5CC);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_wrap_fffe", instr_pc, 16'hFFFE);
    cyc(0, 0, 16'h0, 1);
    cmp("lit_wrap_0000", instr_pc, 16'h0000);
    cyc(0, 0, 16'h0, 0);
    cmp("lit_rst_mid_valid", {15'd0, instr_valid}, 16'd0);
    cmp("lit_rst_mid_pc", imem_pc, 16'h0000);

    // Randomized traffic with a HALT word at 0x40
    halt_en = 1'b1;
    halt_pc = 16'h0040;
    for (int i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(0, 9) < 3);
      r_r = ($urandom_range(0, 19) == 0);
      rpc_r = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15)))
                                          : 16'($urandom_range(0, 127));
      rn_r = ($urandom_range(0, 99) != 0);
      if (halted && $urandom_range(0, 7) == 0) rn_r = 1'b0;
      cyc(s_r, r_r, rpc_r, rn_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
